// File: rtl/arrow_judge.sv
// Per-lane note timing judge: turns debounced arrow levels into presses and grades them against
// pending notes. Build with ARROW_JUDGE_STRAY_PENALTY_EN to clear combo on presses to idle lanes.
module arrow_judge #(
    parameter int unsigned LANES        = 4,
    parameter int unsigned WINDOW       = 32,
    parameter int unsigned PERFECT_HALF = 4,
    parameter int unsigned PTS_PERFECT  = 3,
    parameter int unsigned PTS_GOOD     = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [LANES-1:0]     button_state,
    input  logic                 note_valid,
    input  logic [1:0]           note_lane,
    output logic                 note_ready,
    output logic [LANES-1:0]     judge_valid,
    output logic [2*LANES-1:0]   judge_grade,
    output logic [15:0]          score,
    output logic [7:0]           combo
);

    localparam int unsigned TW   = $clog2(WINDOW);
    localparam int unsigned CW   = $clog2(LANES + 1);
    localparam logic [TW-1:0] TLOAD = TW'(WINDOW - 1);
    localparam logic [TW:0]   HALF  = (TW+1)'(WINDOW / 2);
    localparam logic [TW:0]   PHALF = (TW+1)'(PERFECT_HALF);

    typedef enum logic {StIdle, StPending} lane_st_t;

    lane_st_t            r_state [LANES];
    logic [TW-1:0]       r_timer [LANES];
    logic [LANES-1:0]    r_prev;
    logic [LANES-1:0]    r_judge_valid;
    logic [2*LANES-1:0]  r_judge_grade;
    logic [15:0]         r_score;
    logic [7:0]          r_combo;

    logic [LANES-1:0]    w_busy;
    logic [LANES-1:0]    w_press;
    logic [LANES-1:0]    w_accept;
    logic [LANES-1:0]    w_hit;
    logic [LANES-1:0]    w_miss;
    logic [LANES-1:0]    w_stray;
    logic [LANES-1:0]    w_perfect;
    logic [TW:0]         w_t    [LANES];
    logic [TW:0]         w_diff [LANES];
    logic [2*LANES-1:0]  w_grade;
    logic [17:0]         w_pts;
    logic [CW-1:0]       w_hits;
    logic [17:0]         w_score_sum;
    logic [8:0]          w_combo_sum;
    logic                w_combo_clr;

    always_comb begin
        w_press     = button_state & ~r_prev;
        w_grade     = '0;
        w_pts       = '0;
        w_hits      = '0;
        w_busy      = '0;
        w_accept    = '0;
        w_hit       = '0;
        w_miss      = '0;
        w_stray     = '0;
        w_perfect   = '0;
        for (int i = 0; i < int'(LANES); i++) begin
            w_busy[i]    = (r_state[i] == StPending);
            w_accept[i]  = note_valid && !w_busy[i] && (int'(note_lane) == i);
            w_hit[i]     = w_busy[i] & w_press[i];
            w_miss[i]    = w_busy[i] & ~w_press[i] & (r_timer[i] == '0);
            w_stray[i]   = ~w_busy[i] & w_press[i];
            // Widened unsigned distance from the window centre.
            w_t[i]       = {1'b0, r_timer[i]};
            w_diff[i]    = (w_t[i] >= HALF) ? (w_t[i] - HALF) : (HALF - w_t[i]);
            w_perfect[i] = (w_diff[i] <= PHALF);
            if (w_hit[i]) begin
                w_grade[2*i +: 2] = w_perfect[i] ? 2'b01 : 2'b10;
                w_pts  = w_pts + (w_perfect[i] ? 18'(PTS_PERFECT) : 18'(PTS_GOOD));
                w_hits = w_hits + {{(CW-1){1'b0}}, 1'b1};
            end else if (w_miss[i]) begin
                w_grade[2*i +: 2] = 2'b11;
            end
        end
        w_score_sum = {2'b00, r_score} + w_pts;
        w_combo_sum = {1'b0, r_combo} + 9'(w_hits);
`ifdef ARROW_JUDGE_STRAY_PENALTY_EN
        w_combo_clr = (|w_miss) | (|w_stray);
`else
        w_combo_clr = |w_miss;
`endif
    end

    assign note_ready  = ~w_busy[note_lane];
    assign judge_valid = r_judge_valid;
    assign judge_grade = r_judge_grade;
    assign score       = r_score;
    assign combo       = r_combo;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // All ones so a button held through reset does not read as a press.
            r_prev        <= '1;
            r_judge_valid <= '0;
            r_judge_grade <= '0;
            r_score       <= '0;
            r_combo       <= '0;
            for (int i = 0; i < int'(LANES); i++) begin
                r_state[i] <= StIdle;
                r_timer[i] <= '0;
            end
        end else begin
            r_prev        <= button_state;
            r_judge_valid <= w_hit | w_miss;
            r_judge_grade <= w_grade;
            r_score       <= (w_score_sum[17:16] != 2'b00) ? 16'hFFFF : w_score_sum[15:0];
            if (w_combo_clr) begin
                r_combo <= '0;
            end else begin
                r_combo <= w_combo_sum[8] ? 8'hFF : w_combo_sum[7:0];
            end
            for (int i = 0; i < int'(LANES); i++) begin
                unique case (r_state[i])
                    StIdle: begin
                        if (w_accept[i]) begin
                            r_state[i] <= StPending;
                            r_timer[i] <= TLOAD;
                        end
                    end
                    StPending: begin
                        if (w_hit[i] || w_miss[i]) begin
                            r_state[i] <= StIdle;
                        end else begin
                            r_timer[i] <= r_timer[i] - 1'b1;
                        end
                    end
                    default: r_state[i] <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_arrow_judge.sv
// Bench for arrow_judge: directed scenarios plus random traffic, scored against a note-deadline
// model through an expected-output queue drained by an independent monitor.
module tb_arrow_judge;

    localparam int LANES  = 4;
    localparam int WINDOW = 32;
    localparam int PH     = 4;
`ifdef ARROW_JUDGE_STRAY_PENALTY_EN
    localparam bit PEN = 1'b1;
`else
    localparam bit PEN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  button_state;
    logic        note_valid;
    logic [1:0]  note_lane;
    logic        note_ready;
    logic [3:0]  judge_valid;
    logic [7:0]  judge_grade;
    logic [15:0] score;
    logic [7:0]  combo;

    arrow_judge dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .button_state (button_state),
        .note_valid   (note_valid),
        .note_lane    (note_lane),
        .note_ready   (note_ready),
        .judge_valid  (judge_valid),
        .judge_grade  (judge_grade),
        .score        (score),
        .combo        (combo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  v;
        logic [7:0]  g;
        logic [15:0] s;
        logic [7:0]  c;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;

    // Model: a pending note accepted at edge a is decided at edge e with t = WINDOW + a - e.
    bit         m_busy [LANES];
    int         m_acc  [LANES];
    int         edge_n = 0;
    logic [3:0] m_prev;
    int         m_score, m_combo;
    bit         m_accepted = 1'b0;

    always @(posedge clk) begin
        exp_t       e;
        logic [3:0] press;
        int         pts, hits, t, d, acc_lane;
        bit         miss, stray, acc;
        edge_n++;
        m_accepted = 1'b0;
        e.v = '0;
        e.g = '0;
        if (!rst_n) begin
            for (int l = 0; l < LANES; l++) m_busy[l] = 1'b0;
            m_prev  = 4'hF;
            m_score = 0;
            m_combo = 0;
        end else begin
            pts = 0; hits = 0; miss = 1'b0; stray = 1'b0;
            press    = button_state & ~m_prev;
            acc_lane = int'(note_lane);
            acc      = note_valid && !m_busy[acc_lane];
            for (int l = 0; l < LANES; l++) begin
                t = WINDOW + m_acc[l] - edge_n;
                if (m_busy[l] && press[l]) begin
                    d = t - WINDOW / 2;
                    if (d < 0) d = -d;
                    e.v[l] = 1'b1;
                    if (d <= PH) begin
                        e.g[2*l +: 2] = 2'b01;
                        pts += 3;
                    end else begin
                        e.g[2*l +: 2] = 2'b10;
                        pts += 1;
                    end
                    hits++;
                    m_busy[l] = 1'b0;
                end else if (m_busy[l] && t == 0) begin
                    e.v[l] = 1'b1;
                    e.g[2*l +: 2] = 2'b11;
                    miss = 1'b1;
                    m_busy[l] = 1'b0;
                end else if (!m_busy[l] && press[l]) begin
                    stray = 1'b1;
                end
            end
            if (acc) begin
                m_busy[acc_lane] = 1'b1;
                m_acc[acc_lane]  = edge_n;
                m_accepted       = 1'b1;
            end
            m_prev  = button_state;
            m_score = (m_score + pts > 65535) ? 65535 : m_score + pts;
            if (miss || (PEN && stray)) m_combo = 0;
            else m_combo = (m_combo + hits > 255) ? 255 : m_combo + hits;
        end
        e.s = 16'(m_score);
        e.c = 8'(m_combo);
        sbq.push_back(e);
    end

    always @(posedge clk) begin
        exp_t w;
        logic exp_rdy;
        #1;
        total++;
        if (sbq.size() == 0) begin
            bad++;
            $display("FAIL monitor: queue empty at edge %0d", edge_n);
        end else begin
            w = sbq.pop_front();
            if (judge_valid !== w.v || judge_grade !== w.g || score !== w.s || combo !== w.c) begin
                bad++;
                $display("FAIL outputs edge=%0d got v=%b g=%b s=%0d c=%0d want v=%b g=%b s=%0d c=%0d",
                         edge_n, judge_valid, judge_grade, score, combo, w.v, w.g, w.s, w.c);
            end
        end
        exp_rdy = !m_busy[int'(note_lane)];
        total++;
        if (note_ready !== exp_rdy) begin
            bad++;
            $display("FAIL note_ready edge=%0d got %b want %b", edge_n, note_ready, exp_rdy);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    // Returns at the negedge following the accepting edge (lane timer reads WINDOW-1).
    task automatic offer(input int lane);
        note_valid = 1'b1;
        note_lane  = 2'(lane);
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (m_accepted) break;
        end
        if (!m_accepted) begin
            bad++;
            $display("FAIL offer lane %0d never accepted", lane);
        end
        note_valid = 1'b0;
    endtask

    task automatic pulse(input logic [3:0] m);
        button_state = m;
        tick(1);
        button_state = 4'b0000;
    endtask

    initial begin
        rst_n        = 1'b0;
        button_state = 4'b0001;
        note_valid   = 1'b0;
        note_lane    = 2'd0;

        // Button held through reset must not produce a press.
        tick(3);
        rst_n = 1'b1;
        tick(10);
        check("rst_score", int'(score), 0);
        check("rst_combo", int'(combo), 0);
        check("rst_ready", int'(note_ready), 1);
        button_state = 4'b0000;
        tick(1);

        // PERFECT at the window centre.
        offer(0);
        tick(15);
        pulse(4'b0001);
        check("perf_valid", int'(judge_valid), 1);
        check("perf_grade", int'(judge_grade[1:0]), 1);
        check("perf_score", int'(score), 3);
        check("perf_combo", int'(combo), 1);
        tick(1);
        check("perf_onecycle", int'(judge_valid), 0);

        // GOOD at t=25, then an unpressed note MISSes.
        offer(2);
        tick(6);
        pulse(4'b0100);
        check("good_grade", int'(judge_grade[5:4]), 2);
        check("good_score", int'(score), 4);
        offer(1);
        tick(32);
        check("miss_valid", int'(judge_valid), 4'b0010);
        check("miss_grade", int'(judge_grade[3:2]), 3);
        check("miss_combo", int'(combo), 0);

        // Two hits and a MISS decided on one edge.
        offer(1);
        tick(15);
        offer(0);
        tick(13);
        offer(3);
        tick(1);
        pulse(4'b1001);
        check("par_valid", int'(judge_valid), 4'b1011);
        check("par_grade", int'(judge_grade), 8'b10_00_11_01);
        check("par_score", int'(score), 8);
        check("par_combo", int'(combo), 0);

        // Busy lane back-pressure; press coinciding with acceptance does not hit.
        offer(2);
        note_valid = 1'b1;
        note_lane  = 2'd2;
        #1;
        check("busy_ready", int'(note_ready), 0);
        tick(3);
        pulse(4'b0100);
        check("busy_hit", int'(judge_valid), 4'b0100);
        check("busy_freed", int'(note_ready), 1);
        note_valid = 1'b0;
        tick(1);
        note_valid   = 1'b1;
        button_state = 4'b0100;
        tick(1);
        note_valid   = 1'b0;
        button_state = 4'b0000;
        check("acc_press_novalid", int'(judge_valid), 0);
        tick(32);
        check("acc_press_miss", int'(judge_grade[5:4]), 3);
        check("acc_press_combo", int'(combo), 0);

        // Build combo 5, then a stray press.
        repeat (5) begin
            offer(0);
            pulse(4'b0001);
        end
        tick(1);
        check("pre_stray_combo", int'(combo), 5);
        pulse(4'b0100);
        check("stray_valid", int'(judge_valid), 0);
        check("stray_score", int'(score), 14);
        check("stray_combo", int'(combo), PEN ? 0 : 5);

        // Combo saturation.
        repeat (260) begin
            offer(0);
            pulse(4'b0001);
        end
        tick(1);
        check("combo_sat", int'(combo), 255);
        check("sat_score", int'(score), 274);

        // Random traffic with a mid-run reset.
        for (int c = 0; c < 2000; c++) begin
            if (c == 1000) begin
                rst_n      = 1'b0;
                note_valid = 1'b0;
                tick(2);
                rst_n = 1'b1;
            end
            if (note_valid && m_accepted) note_valid = 1'b0;
            if (!note_valid && $urandom_range(0, 2) == 0) begin
                note_valid = 1'b1;
                note_lane  = 2'($urandom_range(0, 3));
            end
            button_state = button_state ^ (4'($urandom) & 4'($urandom) & 4'($urandom));
            tick(1);
        end
        note_valid   = 1'b0;
        button_state = 4'b0000;
        tick(40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
